// File: rtl/speck_core_arbiter_if.sv
// Handshake bundle between requesters, the arbiter, the encrypt core
// and the response consumer. slave = arbiter side, master = environment.
interface speck_core_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*128-1:0] req_key;
  logic [NUM_REQ*128-1:0] req_plaintext;
  logic                   core_start;
  logic [127:0]           core_key;
  logic [127:0]           core_plaintext;
  logic [127:0]           core_ciphertext;
  logic                   core_finished;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [127:0]           rsp_ciphertext;
  logic                   rsp_error;
  logic                   busy;

  modport slave (
    input  req_valid, req_key, req_plaintext,
    input  core_ciphertext, core_finished, rsp_ready,
    output req_ready, core_start, core_key, core_plaintext,
    output rsp_valid, rsp_id, rsp_ciphertext, rsp_error, busy
  );

  modport master (
    output req_valid, req_key, req_plaintext,
    output core_ciphertext, core_finished, rsp_ready,
    input  req_ready, core_start, core_key, core_plaintext,
    input  rsp_valid, rsp_id, rsp_ciphertext, rsp_error, busy
  );
endinterface

// File: rtl/speck_core_arbiter.sv
// Round-robin sharing of one SPECK128/128 encrypt core across NUM_REQ
// requesters. Ports: clk, rst_n (async low), bus (speck_core_arbiter_if.slave:
// req_* job handshake, core_* operand/start/result, rsp_* tagged result, busy).
// Optional macro SPECK_ARB_TIMEOUT_EN adds a WAIT watchdog (TIMEOUT_CYCLES).
module speck_core_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  speck_core_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, GRANT, START, WAIT, DONE
  } state_t;

  state_t state_q, state_d;

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] id_q;
  logic [ID_W-1:0] sel_id;
  logic [ID_W-1:0] nxt_ptr;
  logic            sel_hit;
  logic            grant_ok;
  logic            timeout;
  logic [127:0]    key_q;
  logic [127:0]    pt_q;
  logic [127:0]    ct_q;

  if (NUM_REQ < 1 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1)
  begin : g_bad_cfg
    $error("speck_core_arbiter: bad parameters");
  end

`ifdef SPECK_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  // Fires on the last permitted WAIT cycle; finished still wins.
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus.rsp_error = err_q;
`else
  assign timeout = 1'b0;
  assign bus.rsp_error = 1'b0;
`endif

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    sel_hit = 1'b0;
    sel_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!sel_hit && bus.req_valid[idx]) begin
        sel_hit = 1'b1;
        sel_id  = ID_W'(idx);
      end
    end
  end

  assign nxt_ptr = (id_q == ID_W'(NUM_REQ - 1)) ?
                   '0 : id_q + 1'b1;

  // A requester that withdraws during GRANT gets no strobe.
  assign grant_ok = (state_q == GRANT) && bus.req_valid[id_q];

  always_comb begin
    bus.req_ready = '0;
    if (grant_ok) bus.req_ready[id_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (sel_hit) state_d = GRANT;
      GRANT: state_d = grant_ok ? START : IDLE;
      START: state_d = WAIT;
      WAIT:  if (bus.core_finished || timeout)
               state_d = DONE;
      DONE:  if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      id_q  <= '0;
      key_q <= '0;
      pt_q  <= '0;
      ct_q  <= '0;
`ifdef SPECK_ARB_TIMEOUT_EN
      cnt_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: if (sel_hit) id_q <= sel_id;
        GRANT: if (grant_ok) begin
          key_q <= bus.req_key[128*id_q +: 128];
          pt_q  <= bus.req_plaintext[128*id_q +: 128];
          ptr_q <= nxt_ptr;
        end
        START: begin
`ifdef SPECK_ARB_TIMEOUT_EN
          cnt_q <= '0;
`endif
        end
        WAIT: begin
`ifdef SPECK_ARB_TIMEOUT_EN
          cnt_q <= cnt_q + 1'b1;
`endif
          if (bus.core_finished) begin
            ct_q <= bus.core_ciphertext;
`ifdef SPECK_ARB_TIMEOUT_EN
            err_q <= 1'b0;
`endif
          end else if (timeout) begin
            ct_q <= '0;
`ifdef SPECK_ARB_TIMEOUT_EN
            err_q <= 1'b1;
`endif
          end
        end
        DONE: if (bus.rsp_ready) begin
          key_q <= '0;
          pt_q  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.core_start     = (state_q == START);
  assign bus.core_key       = key_q;
  assign bus.core_plaintext = pt_q;
  assign bus.rsp_valid      = (state_q == DONE);
  assign bus.rsp_id         = id_q;
  assign bus.rsp_ciphertext = ct_q;
  assign bus.busy           = (state_q != IDLE);

endmodule

// File: tb/tb_speck_core_arbiter.sv
// Directed bench for speck_core_arbiter with a key^plaintext core model
// that raises finished 34 cycles after start.
module tb_speck_core_arbiter;
  localparam int N = 4;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  speck_core_arbiter_if #(.NUM_REQ(N), .ID_W(W)) bus();

  speck_core_arbiter #(
    .NUM_REQ(N), .ID_W(W), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // Core model
  int           mcnt = 0;
  logic         mrun = 1'b0;
  logic         fin_q = 1'b0;
  logic [127:0] mct_q = '0;
  logic         never_fin = 1'b0;

  always @(posedge clk) begin
    if (bus.core_start) begin
      mcnt  <= 0;
      mrun  <= 1'b1;
      fin_q <= 1'b0;
    end else if (mrun) begin
      mcnt <= mcnt + 1;
      if (mcnt == 33 && !never_fin) begin
        fin_q <= 1'b1;
        mrun  <= 1'b0;
        mct_q <= bus.core_key ^ bus.core_plaintext;
      end
    end
  end

  assign bus.core_finished   = fin_q;
  assign bus.core_ciphertext = mct_q;

  int n_cmp = 0;
  int n_bad = 0;
  logic [127:0] key [N];
  logic [127:0] pt  [N];

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int c;
    c = 0;
    while (bus.req_ready == '0 && c < 100) begin
      tick();
      c++;
    end
    chk("ready_wait", 128'(c < 100), 128'd1);
  endtask

  task automatic wait_rsp();
    int c;
    c = 0;
    while (!bus.rsp_valid && c < 100) begin
      tick();
      c++;
    end
    chk("rsp_wait", 128'(c < 100), 128'd1);
  endtask

  task automatic load_bus();
    bus.req_key       = {key[3], key[2], key[1], key[0]};
    bus.req_plaintext = {pt[3], pt[2], pt[1], pt[0]};
  endtask

  initial begin
    int c;
    int starts;
    int seen;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      key[i] = {4{32'h1111_0000 * (i + 1) + 32'h0123}};
      pt[i]  = {4{32'h0A0B_0C0D + 32'h0101 * (i + 7)}};
    end
    key[1] = 128'h753778214125442A472D4B6150645367;
    pt[1]  = 128'he5b2862a6a7d27f3cf1688b3fbc40c13;
    load_bus();

    // Reset state
    tick(); tick();
    chk("rst_busy", 128'(bus.busy), 128'd0);
    chk("rst_ready", 128'(bus.req_ready), 128'd0);
    chk("rst_start", 128'(bus.core_start), 128'd0);
    chk("rst_rspv", 128'(bus.rsp_valid), 128'd0);
    chk("rst_key", bus.core_key, 128'd0);
    chk("rst_id", 128'(bus.rsp_id), 128'd0);
    chk("rst_err", 128'(bus.rsp_error), 128'd0);
    rst_n = 1'b1;
    tick();

    // Single job from requester 1
    bus.req_valid = 4'b0010;
    tick();
    chk("s_ready", 128'(bus.req_ready), 128'h2);
    chk("s_busy", 128'(bus.busy), 128'd1);
    chk("s_nostart", 128'(bus.core_start), 128'd0);
    tick();
    chk("s_start", 128'(bus.core_start), 128'd1);
    chk("s_ready0", 128'(bus.req_ready), 128'd0);
    chk("s_ckey", bus.core_key, key[1]);
    chk("s_cpt", bus.core_plaintext, pt[1]);
    bus.req_valid = '0;
    c = 0;
    starts = 0;
    while (!bus.rsp_valid && c < 100) begin
      tick();
      c++;
      if (bus.core_start) starts++;
    end
    chk("s_lat", 128'(c), 128'd36);
    chk("s_starts", 128'(starts), 128'd0);
    chk("s_id", 128'(bus.rsp_id), 128'd1);
    chk("s_ct", bus.rsp_ciphertext, key[1] ^ pt[1]);
    chk("s_err", 128'(bus.rsp_error), 128'd0);
    bus.rsp_ready = 1'b1;
    tick();
    chk("s_idle", 128'(bus.busy), 128'd0);
    chk("s_rspv0", 128'(bus.rsp_valid), 128'd0);
    chk("s_kclr", bus.core_key, 128'd0);

    // Fresh pointer, then two full rounds with all held valid
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req_valid = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      wait_ready();
      chk("rr_grant", 128'(bus.req_ready), 128'(4'b0001 << (j % 4)));
      wait_rsp();
      chk("rr_id", 128'(bus.rsp_id), 128'(j % 4));
      chk("rr_ct", bus.rsp_ciphertext, key[j % 4] ^ pt[j % 4]);
    end

    // Backpressure on requester 3's response
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_valid", 128'(bus.rsp_valid), 128'd1);
      chk("bp_id", 128'(bus.rsp_id), 128'd3);
      chk("bp_ct", bus.rsp_ciphertext, key[3] ^ pt[3]);
      chk("bp_ready", 128'(bus.req_ready), 128'd0);
    end
    bus.rsp_ready = 1'b1;
    wait_ready();
    chk("bp_grant", 128'(bus.req_ready), 128'h1);
    tick();
    bus.req_valid = '0;
    wait_rsp();
    chk("bp_id0", 128'(bus.rsp_id), 128'd0);
    tick();
    chk("bp_idle", 128'(bus.busy), 128'd0);

    // Reset in the middle of WAIT
    bus.req_valid = 4'b1000;
    wait_ready();
    chk("mr_grant", 128'(bus.req_ready), 128'h8);
    tick();
    bus.req_valid = '0;
    repeat (5) tick();
    chk("mr_busy", 128'(bus.busy), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_busy0", 128'(bus.busy), 128'd0);
    chk("mr_rspv", 128'(bus.rsp_valid), 128'd0);
    chk("mr_start", 128'(bus.core_start), 128'd0);
    chk("mr_key", bus.core_key, 128'd0);
    chk("mr_pt", bus.core_plaintext, 128'd0);
    chk("mr_ct", bus.rsp_ciphertext, 128'd0);
    chk("mr_id", 128'(bus.rsp_id), 128'd0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.rsp_valid) seen++;
    end
    chk("mr_norsp", 128'(seen), 128'd0);
    bus.req_valid = 4'b1111;
    wait_ready();
    chk("mr_grant0", 128'(bus.req_ready), 128'h1);
    tick();
    bus.req_valid = '0;
    wait_rsp();
    chk("mr_rid", 128'(bus.rsp_id), 128'd0);
    chk("mr_rct", bus.rsp_ciphertext, key[0] ^ pt[0]);
    tick();

    // Requester 2 withdraws during GRANT
    bus.req_valid = 4'b0100;
    tick();
    chk("dr_busy", 128'(bus.busy), 128'd1);
    bus.req_valid = '0;
    #1;
    chk("dr_ready", 128'(bus.req_ready), 128'd0);
    tick();
    chk("dr_idle", 128'(bus.busy), 128'd0);
    chk("dr_start", 128'(bus.core_start), 128'd0);
    tick();
    chk("dr_start2", 128'(bus.core_start), 128'd0);
    chk("dr_key", bus.core_key, 128'd0);
    bus.req_valid = 4'b1111;
    wait_ready();
    chk("dr_ptr", 128'(bus.req_ready), 128'h2);
    tick();
    bus.req_valid = '0;
    wait_rsp();
    chk("dr_id", 128'(bus.rsp_id), 128'd1);
    tick();

`ifdef SPECK_ARB_TIMEOUT_EN
    // Core never finishes
    never_fin = 1'b1;
    bus.req_valid = 4'b0001;
    wait_ready();
    tick();
    chk("to_start", 128'(bus.core_start), 128'd1);
    bus.req_valid = '0;
    c = 0;
    while (!bus.rsp_valid && c < 200) begin
      tick();
      c++;
    end
    chk("to_lat", 128'(c), 128'd65);
    chk("to_err", 128'(bus.rsp_error), 128'd1);
    chk("to_ct", bus.rsp_ciphertext, 128'd0);
    tick();
    chk("to_idle", 128'(bus.busy), 128'd0);
    never_fin = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
